// File: rtl/digit_serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
package digit_serial_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Number of digit cycles per operation.
   function automatic int ndig(input int width, input int digit);
      return width / digit;
   endfunction

   // Digit counter width; a single-digit configuration still gets one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Legal geometry: WIDTH is a whole number of digits, at least one.
   function automatic bit width_ok(input int width, input int digit);
      return (digit > 0) && (width >= digit) && ((width % digit) == 0);
   endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// Operand/result handshake bundle for the digit-serial adder.
interface digit_serial_adder_if #(parameter int WIDTH = 16);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic             sub;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] sum;
   logic             co;
   logic             ovf;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output a, b, ci, sub, in_valid, out_ready,
      input  in_ready, sum, co, ovf, out_valid
   );

   modport slave (
      input  a, b, ci, sub, in_valid, out_ready,
      output in_ready, sum, co, ovf, out_valid
   );
endinterface

// File: rtl/digit_serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into the top bit
// so the caller can derive signed overflow as carry-in(msb) ^ carry-out.
module digit_adder #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a_i,
   input  logic [DIGIT-1:0] b_i,
   input  logic             ci_i,
   output logic [DIGIT-1:0] s_o,
   output logic             co_o,
   output logic             msb_ci_o
);

   // Full-adder chain, each stage two half adders plus carry merge.
   always_comb begin : ripple
      logic c;
      logic hs;
      c        = ci_i;
      hs       = 1'b0;
      s_o      = '0;
      msb_ci_o = 1'b0;
      for (int i = 0; i < DIGIT; i++) begin
         if (i == DIGIT - 1) msb_ci_o = c;
         hs     = a_i[i] ^ b_i[i];
         s_o[i] = hs ^ c;
         c      = (a_i[i] & b_i[i]) | (hs & c);
      end
      co_o = c;
   end

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract: WIDTH-bit operands processed DIGIT bits per cycle,
// carry held in a single flop between digits.
//
//   state | meaning
//   IDLE  | waiting for an operand pair, in_ready high
//   RUN   | adding one digit per cycle, low digit first
//   DONE  | result presented, held until out_ready
module digit_serial_adder
   import digit_serial_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   digit_serial_adder_if.slave bus
);

   localparam int NDIG  = ndig(WIDTH, DIGIT);
   localparam int CNT_W = cnt_width(NDIG);

   if (!width_ok(WIDTH, DIGIT)) begin : g_bad_geometry
      $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
   end

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d, co_q, co_d, ovf_q, ovf_d;
   logic             in_ready_q, in_ready_d;

   logic [DIGIT-1:0] dig_a, dig_b, dig_s;
   logic             dig_co, dig_msb_ci, last_dig;

   assign dig_a    = a_q[int'(cnt_q)*DIGIT +: DIGIT];
   assign dig_b    = b_q[int'(cnt_q)*DIGIT +: DIGIT];
   assign last_dig = (cnt_q == CNT_W'(NDIG - 1));

   digit_adder #(.DIGIT(DIGIT)) u_digit (
      .a_i      (dig_a),
      .b_i      (dig_b),
      .ci_i     (carry_q),
      .s_o      (dig_s),
      .co_o     (dig_co),
      .msb_ci_o (dig_msb_ci)
   );

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state and datapath updates; subtraction stores ~B with carry seeded to 1.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      co_d    = co_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               a_d     = bus.a;
               b_d     = bus.sub ? ~bus.b : bus.b;
               carry_d = bus.sub ? 1'b1 : bus.ci;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            res_d[int'(cnt_q)*DIGIT +: DIGIT] = dig_s;
            carry_d = dig_co;
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_dig) begin
               cnt_d   = '0;
               sum_d   = res_d;
               co_d    = dig_co;
               // Same-sign operands with a flipped result sign is exactly msb carry-in != carry-out.
               ovf_d   = dig_msb_ci ^ dig_co;
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      in_ready_d = (state_d == IDLE);
   end

   // Operand, result, carry and output registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         a_q        <= '0;
         b_q        <= '0;
         res_q      <= '0;
         carry_q    <= 1'b0;
         cnt_q      <= '0;
         sum_q      <= '0;
         co_q       <= 1'b0;
         ovf_q      <= 1'b0;
         in_ready_q <= 1'b0;
      end else begin
         a_q        <= a_d;
         b_q        <= b_d;
         res_q      <= res_d;
         carry_q    <= carry_d;
         cnt_q      <= cnt_d;
         sum_q      <= sum_d;
         co_q       <= co_d;
         ovf_q      <= ovf_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = (state_q == DONE);
   assign bus.sum       = sum_q;
   assign bus.co        = co_q;
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: four DIGIT configurations (1, 4, 8, 16) at WIDTH=16.
// Directed scenarios run on the DIGIT=4 instance; random sweeps on all four.
module tb_digit_serial_adder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [3:0][15:0] a_s, b_s, sum_s;
   logic [3:0]       ci_s, sub_s, iv_s, or_s, co_s, ovf_s, ov_s, ir_s;

   int checks = 0;
   int errors = 0;

   for (genvar g = 0; g < 4; g++) begin : g_cfg
      localparam int D = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : 16;
      digit_serial_adder_if #(.WIDTH(16)) bus ();
      assign bus.a         = a_s[g];
      assign bus.b         = b_s[g];
      assign bus.ci        = ci_s[g];
      assign bus.sub       = sub_s[g];
      assign bus.in_valid  = iv_s[g];
      assign bus.out_ready = or_s[g];
      assign sum_s[g]      = bus.sum;
      assign co_s[g]       = bus.co;
      assign ovf_s[g]      = bus.ovf;
      assign ov_s[g]       = bus.out_valid;
      assign ir_s[g]       = bus.in_ready;
      digit_serial_adder #(.WIDTH(16), .DIGIT(D)) dut (
         .clk_i (clk),
         .rst_i (rst),
         .bus   (bus)
      );
   end

   function automatic int dig_of(input int sel);
      case (sel)
         0: return 1;
         1: return 4;
         2: return 8;
         default: return 16;
      endcase
   endfunction

   // Integer-arithmetic reference: unsigned result/carry and signed range check.
   function automatic void ref_model(input logic [15:0] a, input logic [15:0] b,
                                     input logic ci, input logic sub,
                                     output logic [15:0] s, output logic c, output logic o);
      int ua, ub, sa, sb, u, sv;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sub) begin
         u  = ua - ub;
         c  = (ua >= ub);
         sv = sa - sb;
      end else begin
         u  = ua + ub + int'(ci);
         c  = (u > 65535);
         sv = sa + sb + int'(ci);
      end
      s = u[15:0];
      o = (sv > 32767) || (sv < -32768);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction; hold = extra cycles with out_ready low in DONE.
   task automatic do_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic sub, input int hold,
                        output logic [15:0] s, output logic c, output logic o, output int lat);
      int guard = 0;
      while (!ir_s[sel] && guard < 200) begin
         tick();
         guard++;
      end
      checks++;
      if (ir_s[sel] !== 1'b1) begin
         errors++;
         $display("FAIL in_ready_wait sel=%0d got %b want 1", sel, ir_s[sel]);
      end
      a_s[sel] = a; b_s[sel] = b; ci_s[sel] = ci; sub_s[sel] = sub;
      iv_s[sel] = 1'b1;
      or_s[sel] = 1'b0;
      tick();
      iv_s[sel] = 1'b0;
      a_s[sel] = 16'($urandom); b_s[sel] = 16'($urandom);
      ci_s[sel] = 1'($urandom); sub_s[sel] = 1'($urandom);
      lat = 0;
      while (!ov_s[sel] && lat < 200) begin
         tick();
         lat++;
      end
      s = sum_s[sel]; c = co_s[sel]; o = ovf_s[sel];
      repeat (hold) tick();
      or_s[sel] = 1'b1;
      tick();
      or_s[sel] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({ov_s[k], ir_s[k], sum_s[k], co_s[k], ovf_s[k]} !== 20'h0) begin
            errors++;
            $display("FAIL reset_state sel=%0d got ov=%b ir=%b sum=%h co=%b ovf=%b want all 0",
                     k, ov_s[k], ir_s[k], sum_s[k], co_s[k], ovf_s[k]);
         end
      end
      rst = 1'b0;
      tick();
      checks++;
      if (ir_s[1] !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready got %b want 1", ir_s[1]);
      end
   endtask

   task automatic test_add();
      logic [15:0] s; logic c, o; int lat;
      do_op(1, 16'h1234, 16'h0FCD, 1'b0, 1'b0, 0, s, c, o, lat);
      checks++;
      if (lat !== 4) begin
         errors++;
         $display("FAIL add_latency got %0d want 4", lat);
      end
      checks++;
      if ({s, c, o} !== {16'h2201, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL add_basic got %h/%b/%b want 2201/0/0", s, c, o);
      end
   endtask

   task automatic test_carry_ovf();
      logic [15:0] s; logic c, o; int lat;
      do_op(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, s, c, o, lat);
      checks++;
      if ({s, c, o} !== {16'h0000, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL add_carry got %h/%b/%b want 0000/1/0", s, c, o);
      end
      do_op(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, s, c, o, lat);
      checks++;
      if ({s, c, o} !== {16'h8000, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL add_overflow got %h/%b/%b want 8000/0/1", s, c, o);
      end
      do_op(1, 16'h00FF, 16'h0000, 1'b1, 1'b0, 0, s, c, o, lat);
      checks++;
      if ({s, c, o} !== {16'h0100, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL add_carry_in got %h/%b/%b want 0100/0/0", s, c, o);
      end
   endtask

   task automatic test_sub();
      logic [15:0] s; logic c, o; int lat;
      do_op(1, 16'h0005, 16'h0007, 1'b0, 1'b1, 0, s, c, o, lat);
      checks++;
      if ({s, c, o} !== {16'hFFFE, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL sub_borrow got %h/%b/%b want FFFE/0/0", s, c, o);
      end
      do_op(1, 16'h8000, 16'h0001, 1'b0, 1'b1, 0, s, c, o, lat);
      checks++;
      if ({s, c, o} !== {16'h7FFF, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL sub_overflow got %h/%b/%b want 7FFF/1/1", s, c, o);
      end
      do_op(1, 16'h0005, 16'h0007, 1'b1, 1'b1, 0, s, c, o, lat);
      checks++;
      if ({s, c, o} !== {16'hFFFE, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL sub_ignores_ci got %h/%b/%b want FFFE/0/0", s, c, o);
      end
   endtask

   task automatic test_backpressure();
      a_s[1] = 16'h7FFF; b_s[1] = 16'h0001; ci_s[1] = 1'b0; sub_s[1] = 1'b0;
      iv_s[1] = 1'b1; or_s[1] = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         a_s[1] = 16'($urandom); b_s[1] = 16'($urandom);
         sub_s[1] = 1'($urandom); ci_s[1] = 1'($urandom);
         iv_s[1] = (i % 2 == 0);
         tick();
      end
      iv_s[1] = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({ov_s[1], ir_s[1], sum_s[1], co_s[1], ovf_s[1]} !== {1'b1, 1'b0, 16'h8000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL hold_done cyc=%0d got ov=%b ir=%b sum=%h co=%b ovf=%b want 1/0/8000/0/1",
                     i, ov_s[1], ir_s[1], sum_s[1], co_s[1], ovf_s[1]);
         end
         tick();
      end
      or_s[1] = 1'b1;
      tick();
      or_s[1] = 1'b0;
      checks++;
      if ({ov_s[1], ir_s[1], sum_s[1]} !== {1'b0, 1'b1, 16'h8000}) begin
         errors++;
         $display("FAIL release_done got ov=%b ir=%b sum=%h want 0/1/8000", ov_s[1], ir_s[1], sum_s[1]);
      end
   endtask

   task automatic test_reset_midrun();
      logic [15:0] s; logic c, o; int lat;
      a_s[1] = 16'h1111; b_s[1] = 16'h2222; ci_s[1] = 1'b0; sub_s[1] = 1'b0;
      iv_s[1] = 1'b1;
      tick();
      iv_s[1] = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      checks++;
      if ({ov_s[1], ir_s[1], sum_s[1], co_s[1], ovf_s[1]} !== 20'h0) begin
         errors++;
         $display("FAIL reset_midrun got ov=%b ir=%b sum=%h co=%b ovf=%b want all 0",
                  ov_s[1], ir_s[1], sum_s[1], co_s[1], ovf_s[1]);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (ir_s[1] !== 1'b1) begin
         errors++;
         $display("FAIL reset_midrun_ready got %b want 1", ir_s[1]);
      end
      do_op(1, 16'h0001, 16'h0001, 1'b0, 1'b0, 0, s, c, o, lat);
      checks++;
      if ({s, c, o} !== {16'h0002, 1'b0, 1'b0} || lat !== 4) begin
         errors++;
         $display("FAIL after_reset_add got %h/%b/%b lat=%0d want 0002/0/0 lat=4", s, c, o, lat);
      end
   endtask

   task automatic test_sweep(input int sel);
      logic [15:0] a, b, s, es;
      logic ci, sub, c, o, ec, eo;
      int lat, hold, want_lat;
      want_lat = 16 / dig_of(sel);
      for (int i = 0; i < 1000; i++) begin
         a = 16'($urandom); b = 16'($urandom);
         ci = 1'($urandom); sub = 1'($urandom);
         if (i == 0) begin a = 16'hFFFF; b = 16'h0001; sub = 1'b0; ci = 1'b1; end
         if (i == 1) begin a = 16'h8000; b = 16'h7FFF; sub = 1'b1; end
         if (i == 2) begin a = 16'h0000; b = 16'h8000; sub = 1'b1; end
         hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         do_op(sel, a, b, ci, sub, hold, s, c, o, lat);
         ref_model(a, b, ci, sub, es, ec, eo);
         checks++;
         if (lat !== want_lat) begin
            errors++;
            $display("FAIL sweep_latency digit=%0d op=%0d got %0d want %0d", dig_of(sel), i, lat, want_lat);
         end
         checks++;
         if ({s, c, o} !== {es, ec, eo}) begin
            errors++;
            $display("FAIL sweep_result digit=%0d op=%0d a=%h b=%h ci=%b sub=%b got %h/%b/%b want %h/%b/%b",
                     dig_of(sel), i, a, b, ci, sub, s, c, o, es, ec, eo);
         end
      end
   endtask

   initial begin
      a_s = '0; b_s = '0; ci_s = '0; sub_s = '0; iv_s = '0; or_s = '0;
      rst = 1'b1;
      test_reset();
      test_add();
      test_carry_ovf();
      test_sub();
      test_backpressure();
      test_reset_midrun();
      for (int k = 0; k < 4; k++) test_sweep(k);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/digit_serial_adder.md
# digit_serial_adder

Parametrised, clocked adder/subtractor that processes a WIDTH-bit operand pair DIGIT bits per cycle, rippling the carry through a registered carry flop between digits. It is the sequential, width-generalised successor of the single-bit half-adder cell. It adds add/subtract mode, carry-in, signed overflow and a valid/ready handshake on both sides. It sits in the datapath library as an area-lean alternative to a full-width ripple adder when latency is acceptable.

## Interface
- WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT, and WIDTH ≥ DIGIT.
- DIGIT, 4, bits added per cycle; NDIG = WIDTH/DIGIT cycles per operation.
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- A  in  WIDTH  operand A; sampled only on accept.
- B  in  WIDTH  operand B; sampled only on accept.
- CI  in  1  carry-in for ADD; sampled on accept; ignored for SUB.
- SUB  in  1  0 = A+B+CI, 1 = A−B, computed as A+~B+1; sampled on accept.
- IN_VALID  in  1  operand pair presented.
- IN_READY  out  1  block can accept; high only in IDLE.
- SUM  out  WIDTH  result.
- CO  out  1  carry-out of the MSB. In SUB, 1 means no borrow.
- OVF  out  1  two's-complement signed overflow.
- OUT_VALID  out  1  SUM/CO/OVF valid.
- OUT_READY  in  1  consumer takes the result.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: IN_READY=1. On IN_VALID=1, an accept occurs:
  - latch A, B (inverted if SUB), SUB;
  - seed the carry flop with CI (ADD) or 1 (SUB);
  - clear the digit counter; go to RUN.
- RUN: each cycle adds digit k (bits k·DIGIT … k·DIGIT+DIGIT−1) of the latched operands plus the carry flop.
  - The DIGIT-bit sum goes into the internal result register at digit k.
  - The carry-out goes into the carry flop.
  - The counter increments.
  - On k = NDIG−1, go to DONE and load the outputs:
    - SUM = full result;
    - CO = final carry;
    - OVF = (A[MSB] == B'[MSB]) && (SUM[MSB] != A[MSB]), where B' is the post-inversion operand.
- DONE: OUT_VALID=1 and outputs stay stable. On OUT_READY=1, go to IDLE.
- SUM/CO/OVF change only on the RUN→DONE transition. They keep their value through IDLE and the next RUN.
- Input changes on A/B/CI/SUB outside the accept cycle have no effect.
- Width rule: the internal carry is 1 bit; the per-digit adder is DIGIT+1 bits wide; there is no wider accumulation.
- Reset values (and state while RST=1): state=IDLE, SUM=0, CO=0, OVF=0, OUT_VALID=0, IN_READY=0 during reset, counter=0, carry flop=0.
- Reset in any state aborts the operation with no partial result. The first cycle after RST deasserts is IDLE with IN_READY=1.

## Timing
- Accept on edge t0 → RUN for cycles t0 … t0+NDIG−1 → OUT_VALID=1 from edge t0+NDIG.
- Output handshake on edge t1 → IDLE at t1, with IN_READY=1 in the cycle after t1.
- No accept happens in the same cycle as the output handshake.
- Maximum throughput: one operation per NDIG+2 cycles.
- DIGIT = WIDTH gives NDIG=1, i.e. a single RUN cycle. This must work.
- IN_READY is a registered function of state only and has no combinational path from OUT_READY.
- OUT_READY low holds DONE indefinitely, with all outputs unchanged.
- The critical path is one DIGIT-bit ripple plus the carry flop setup.

## Structure
- Shared package digit_serial_pkg:
  - state enum {IDLE, RUN, DONE};
  - localparam helper for NDIG and the counter width $clog2(NDIG) (min 1);
  - elaboration check that WIDTH % DIGIT == 0.
- Sub-module digit_adder (parameter DIGIT): a combinational DIGIT-bit ripple adder built from a half-adder/full-adder chain.
  - Inputs: a, b, ci. Outputs: s, co.
  - Also exports the MSB carry-in so overflow can be cross-checked.
- The top level holds the FSM, counter, operand/result registers and carry flop.

## Test plan
All cases use WIDTH=16, DIGIT=4 unless noted.
- ADD: A=0x1234, B=0x0FCD, CI=0, SUB=0 → OUT_VALID exactly 4 edges after accept; SUM=0x2201, CO=0, OVF=0.
- Carry/overflow: 0xFFFF+0x0001 → SUM=0x0000, CO=1, OVF=0. Then 0x7FFF+0x0001 → SUM=0x8000, CO=0, OVF=1. Then ADD with CI=1: 0x00FF+0x0000 → SUM=0x0100.
- SUB: 0x0005−0x0007 → SUM=0xFFFE, CO=0. Then 0x8000−0x0001 → SUM=0x7FFF, CO=1, OVF=1. CI=1 has no effect in SUB.
- Backpressure: hold OUT_READY=0 for 5 cycles in DONE → SUM/CO/OVF/OUT_VALID stable, IN_READY=0. Toggle A/B/IN_VALID during RUN → result unchanged.
- Reset: assert RST on the 2nd RUN cycle → next cycle all outputs 0. After release, IN_READY=1 and a fresh 0x0001+0x0001 gives 0x0002.
- Sweep DIGIT ∈ {1, 4, 8, 16}: random 1000 operations per configuration against a reference model, including back-to-back accepts → latency = WIDTH/DIGIT and results match the reference.
